// File: rtl/noc_out_port_arbiter.sv
// Packet-granular round-robin switch allocator for one router output port.
// Defining NOC_ARB_WATCHDOG_EN adds a stall watchdog that aborts a stuck grant and pulses err_o.
module noc_out_port_arbiter #(
  parameter int NUM_IN   = 5,
  parameter int FLIT_W   = 16,
  parameter int WD_LIMIT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*FLIT_W-1:0] in_data_i,
  input  logic [NUM_IN-1:0]        in_valid_i,
  input  logic                     out_ready_i,
  output logic [NUM_IN-1:0]        buf_read_o,
  output logic [NUM_IN-1:0]        grant_o,
  output logic [FLIT_W-1:0]        out_data_o,
  output logic                     out_valid_o,
  output logic                     err_o
);
  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  gidx_q, gidx_d;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [NUM_IN-1:0] rd_q, rd_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic [FLIT_W-1:0] sel_flit;
  logic              vld_q, vld_d;

  if (NUM_IN < 2 || FLIT_W < 2 || WD_LIMIT < 1) begin : g_param_check
    $error("noc_out_port_arbiter: invalid parameter values");
  end

  // Modulo-NUM_IN increment; NUM_IN need not be a power of two.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_IN - 1)) return '0;
    return idx + PTR_W'(1);
  endfunction

  always_comb begin
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign sel_flit = in_data_i[gidx_q*FLIT_W +: FLIT_W];

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    rd_d     = '0;
    data_d   = data_q;
    vld_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gidx_d  = win_idx;
          grant_d = NUM_IN'(1) << win_idx;
          state_d = READ;
        end
      end
      READ: begin
        if (req_i[gidx_q] && out_ready_i) begin
          rd_d    = grant_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (in_valid_i[gidx_q]) begin
          data_d = sel_flit;
          vld_d  = 1'b1;
          // Tail flit closes the packet and hands priority to the next buffer.
          if (sel_flit[FLIT_W-2]) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_idx(gidx_q);
          end else begin
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef NOC_ARB_WATCHDOG_EN
    wd_d  = '0;
    err_d = 1'b0;
    if ((state_q == READ || state_q == WAIT) && !vld_d) begin
      if (wd_q == WD_W'(WD_LIMIT - 1)) begin
        err_d    = 1'b1;
        state_d  = IDLE;
        grant_d  = '0;
        rd_d     = '0;
        rr_ptr_d = next_idx(gidx_q);
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
`ifdef NOC_ARB_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
`ifdef NOC_ARB_WATCHDOG_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  assign buf_read_o  = rd_q;
  assign grant_o     = grant_q;
  assign out_data_o  = data_q;
  assign out_valid_o = vld_q;
`ifdef NOC_ARB_WATCHDOG_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Bench for noc_out_port_arbiter: modelled input buffers, directed timing steps and
// randomized packet mixes checked against a packet-level round-robin reference.
module tb_noc_out_port_arbiter;
  localparam int NUM_IN   = 5;
  localparam int FLIT_W   = 16;
  localparam int WD_LIMIT = 15;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_IN-1:0]        req_i = '0;
  logic [NUM_IN*FLIT_W-1:0] in_data_i = '0;
  logic [NUM_IN-1:0]        in_valid_i = '0;
  logic                     out_ready_i = 1'b1;
  logic [NUM_IN-1:0]        buf_read_o;
  logic [NUM_IN-1:0]        grant_o;
  logic [FLIT_W-1:0]        out_data_o;
  logic                     out_valid_o;
  logic                     err_o;

  noc_out_port_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .WD_LIMIT(WD_LIMIT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .out_ready_i(out_ready_i), .buf_read_o(buf_read_o),
    .grant_o(grant_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  logic [FLIT_W-1:0] bufq [NUM_IN][$];
  logic [FLIT_W-1:0] mq [NUM_IN][$];
  logic [FLIT_W-1:0] exp_q [$];
  int grant_log [$];
  int exp_log [$];
  logic [NUM_IN-1:0] prev_grant = '0;
  bit pend_vld = 1'b0;
  int pend_idx = 0;
  logic [FLIT_W-1:0] pend_data = '0;
  bit rnd_mode = 1'b0;
  int err_cnt = 0;
  int err_gap = -1;
  int last_vld_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mkflit(input bit head, input bit tail);
    logic [FLIT_W-3:0] pl;
    pl = (FLIT_W-2)'($urandom);
    return {head, tail, pl};
  endfunction

  // One clock: observe outputs just after the edge, then let the buffer model react.
  task automatic cyc();
    logic [FLIT_W-1:0] e;
    @(posedge clk);
    #1;
    cycle_no++;
    if (!reset) begin
      chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
      chk("read_outside_grant", 32'(buf_read_o & ~grant_o), 32'd0);
      if (out_valid_o === 1'b1) begin
        last_vld_cyc = cycle_no;
        if (exp_q.size() == 0) chk("unexpected_flit", 32'(out_valid_o), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("flit_data", 32'(out_data_o), 32'(e));
        end
      end
      if (err_o === 1'b1) begin
        err_cnt++;
        err_gap = cycle_no - last_vld_cyc;
        chk("grant_after_err", 32'(grant_o), 32'd0);
      end
      if (grant_o != '0 && grant_o != prev_grant)
        for (int i = 0; i < NUM_IN; i++) if (grant_o[i]) grant_log.push_back(i);
      prev_grant = grant_o;
    end
    in_valid_i = '0;
    if (rnd_mode)
      for (int i = 0; i < NUM_IN; i++)
        if (!grant_o[i]) begin
          in_valid_i[i] = 1'($urandom_range(0, 1));
          in_data_i[i*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
        end
    if (pend_vld) begin
      in_valid_i[pend_idx] = 1'b1;
      in_data_i[pend_idx*FLIT_W +: FLIT_W] = pend_data;
      pend_vld = 1'b0;
    end
    for (int i = 0; i < NUM_IN; i++)
      if (buf_read_o[i] === 1'b1) begin
        if (bufq[i].size() == 0) chk("read_of_empty_buffer", 32'(buf_read_o[i]), 32'd0);
        else begin
          pend_vld  = 1'b1;
          pend_idx  = i;
          pend_data = bufq[i].pop_front();
        end
      end
    for (int i = 0; i < NUM_IN; i++) req_i[i] = (bufq[i].size() != 0);
    if (rnd_mode) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0) || pend_vld || (grant_o != '0);
    for (int i = 0; i < NUM_IN; i++) if (bufq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_completes"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, grant_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
      chk(tag, grant_log[i], exp_log[i]);
    grant_log.delete();
    exp_log.delete();
  endtask

  task automatic load(input int b, input logic [FLIT_W-1:0] f);
    bufq[b].push_back(f);
    req_i[b] = 1'b1;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NUM_IN; i++) bufq[i].delete();
    exp_q.delete();
    grant_log.delete();
    exp_log.delete();
    pend_vld   = 1'b0;
    in_valid_i = '0;
    req_i      = '0;
    reset      = 1'b1;
    cyc();
    cyc();
    reset      = 1'b0;
    prev_grant = '0;
  endtask

  // Reference: serve whole packets in round-robin order over the non-empty buffers.
  task automatic build_expectation();
    int ptr, g;
    bit any;
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < NUM_IN; i++) mq[i] = bufq[i];
    ptr = 0;
    any = 1'b1;
    while (any) begin
      g = -1;
      for (int k = 0; k < NUM_IN; k++)
        if (g < 0 && mq[(ptr + k) % NUM_IN].size() > 0) g = (ptr + k) % NUM_IN;
      if (g < 0) any = 1'b0;
      else begin
        exp_log.push_back(g);
        do begin
          f = mq[g].pop_front();
          exp_q.push_back(f);
        end while (!f[FLIT_W-2]);
        ptr = (g + 1) % NUM_IN;
      end
    end
  endtask

  initial begin
    int npk, len;
    reset_dut();
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_read", 32'(buf_read_o), 32'd0);
    chk("reset_data", 32'(out_data_o), 32'd0);
    chk("reset_valid", 32'(out_valid_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);

    load(0, 16'hC123);
    exp_q.push_back(16'hC123);
    cyc();
    chk("t1_grant", 32'(grant_o), 32'h01);
    chk("t1_read_early", 32'(buf_read_o), 32'd0);
    cyc();
    chk("t1_read", 32'(buf_read_o), 32'h01);
    cyc();
    chk("t1_read_single", 32'(buf_read_o), 32'd0);
    chk("t1_valid_early", 32'(out_valid_o), 32'd0);
    cyc();
    chk("t1_valid", 32'(out_valid_o), 32'd1);
    chk("t1_data", 32'(out_data_o), 32'hC123);
    chk("t1_grant_released", 32'(grant_o), 32'd0);
    exp_log.push_back(0);
    check_log("t1_order");

    load(0, 16'hC0A0);
    load(1, 16'hC1A1);
    exp_q.push_back(16'hC1A1);
    exp_q.push_back(16'hC0A0);
    exp_log.push_back(1);
    exp_log.push_back(0);
    drain("ptr_after_tail", 100);
    check_log("ptr_after_tail_order");

    reset_dut();
    load(0, 16'hC010);
    load(0, 16'hC011);
    load(2, 16'hC020);
    load(4, 16'hC040);
    exp_q.push_back(16'hC010);
    exp_q.push_back(16'hC020);
    exp_q.push_back(16'hC040);
    exp_q.push_back(16'hC011);
    exp_log.push_back(0);
    exp_log.push_back(2);
    exp_log.push_back(4);
    exp_log.push_back(0);
    drain("rr10101", 200);
    check_log("rr10101_order");

    load(1, 16'h8001);
    load(1, 16'h0002);
    load(1, 16'h4003);
    load(3, 16'hC0DE);
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h4003);
    exp_q.push_back(16'hC0DE);
    exp_log.push_back(1);
    exp_log.push_back(3);
    drain("multiflit", 200);
    check_log("multiflit_order");

    out_ready_i = 1'b0;
    load(2, 16'hC222);
    exp_q.push_back(16'hC222);
    cyc();
    chk("stall_grant", 32'(grant_o), 32'h04);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_no_read", 32'(buf_read_o), 32'd0);
    end
    out_ready_i = 1'b1;
    cyc();
    chk("stall_read_after_ready", 32'(buf_read_o), 32'h04);
    exp_log.push_back(2);
    drain("stall", 100);
    check_log("stall_order");

    load(0, 16'hC0FF);
    cyc();
    chk("rstwait_grant", 32'(grant_o), 32'h01);
    cyc();
    chk("rstwait_read", 32'(buf_read_o), 32'h01);
    cyc();
    reset = 1'b1;
    cyc();
    chk("rstwait_grant_cleared", 32'(grant_o), 32'd0);
    chk("rstwait_read_cleared", 32'(buf_read_o), 32'd0);
    chk("rstwait_valid_cleared", 32'(out_valid_o), 32'd0);
    chk("rstwait_data_cleared", 32'(out_data_o), 32'd0);
    chk("rstwait_err_cleared", 32'(err_o), 32'd0);
    reset = 1'b0;
    prev_grant = '0;
    in_valid_i[0] = 1'b1;
    in_data_i[0 +: FLIT_W] = 16'hC0FF;
    cyc();
    chk("rstwait_late_flit_dropped", 32'(out_valid_o), 32'd0);
    cyc();
    chk("rstwait_still_idle", 32'(grant_o), 32'd0);
    grant_log.delete();
    load(1, 16'hC1B1);
    load(4, 16'hC4B4);
    exp_q.push_back(16'hC1B1);
    exp_q.push_back(16'hC4B4);
    exp_log.push_back(1);
    exp_log.push_back(4);
    drain("ptr_after_reset", 100);
    check_log("ptr_after_reset_order");

    for (int r = 0; r < 3; r++) begin
      reset_dut();
      for (int b = 0; b < NUM_IN; b++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) load(b, mkflit(j == 0, j == len - 1));
        end
      end
      build_expectation();
      rnd_mode = 1'b1;
      drain("random", 3000);
      rnd_mode    = 1'b0;
      out_ready_i = 1'b1;
      check_log("random_order");
    end

`ifdef NOC_ARB_WATCHDOG_EN
    reset_dut();
    err_cnt = 0;
    load(2, 16'h8A02);
    load(3, 16'hC0D3);
    exp_q.push_back(16'h8A02);
    exp_q.push_back(16'hC0D3);
    exp_log.push_back(2);
    exp_log.push_back(3);
    drain("watchdog", 300);
    chk("wd_err_pulses", err_cnt, 32'd1);
    chk("wd_err_delay", err_gap, WD_LIMIT);
    check_log("wd_order");
`else
    chk("no_err_during_run", err_cnt, 32'd0);
    reset_dut();
    load(2, 16'h8A02);
    load(3, 16'hC0D3);
    exp_q.push_back(16'h8A02);
    repeat (40) cyc();
    chk("stuck_grant_held", 32'(grant_o), 32'h04);
    chk("stuck_no_err", err_cnt, 32'd0);
    reset_dut();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
